ysyx_24120013_exu_ctrl: RTL

Multi-cycle instruction sequencer for the single-issue core. It owns the PC and instruction register, and fetches from instruction memory over a valid/ready request plus a valid response channel. It steps IDU/EXU through EXEC, then gates the EXU write into the register file in a single WB cycle. It also detects halt conditions (ebreak, illegal instruction, fetch error or timeout) and keeps cycle and retired-instruction counters.

---
 rtl/ysyx_24120013_exu_ctrl_if.sv | 44 ++++
 rtl/ysyx_24120013_exu_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ysyx_24120013_exu_ctrl_if.sv
// Sequencer-side bundle: instruction fetch channel, IDU/EXU controls, RF write port and status.
interface ysyx_24120013_exu_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [DATA_WIDTH-1:0] ifu_req_addr;
  logic                  ifu_rsp_valid;
  logic [31:0]           ifu_rsp_data;
  logic                  ifu_rsp_err;
  logic [31:0]           inst;
  logic [DATA_WIDTH-1:0] pc;
  logic                  dec_illegal;
  logic                  dec_ebreak;
  logic                  dec_jump;
  logic [DATA_WIDTH-1:0] dec_jump_target;
  logic                  exu_wen;
  logic [ADDR_WIDTH-1:0] exu_waddr;
  logic [DATA_WIDTH-1:0] exu_wdata;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  halt;
  logic [1:0]            trap_cause;
  logic [DATA_WIDTH-1:0] cycle_cnt;
  logic [DATA_WIDTH-1:0] inst_cnt;

  modport master (
    output ifu_req_valid, ifu_req_addr, inst, pc,
    output rf_wen, rf_waddr, rf_wdata, halt, trap_cause, cycle_cnt, inst_cnt,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    input  dec_illegal, dec_ebreak, dec_jump, dec_jump_target,
    input  exu_wen, exu_waddr, exu_wdata
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr, inst, pc,
    input  rf_wen, rf_waddr, rf_wdata, halt, trap_cause, cycle_cnt, inst_cnt,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    output dec_illegal, dec_ebreak, dec_jump, dec_jump_target,
    output exu_wen, exu_waddr, exu_wdata
  );
endinterface

// File: rtl/ysyx_24120013_exu_ctrl.sv
// Multi-cycle sequencer owning PC/IR: FETCH_REQ -> FETCH_WAIT -> EXEC -> WB, at least 4 cycles per instruction.
// Request held until ready; response awaited up to FETCH_TIMEOUT cycles; any halt is sticky until reset.
module ysyx_24120013_exu_ctrl #(
  parameter int                    ADDR_WIDTH    = 5,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = 32'h8000_0000,
  parameter int                    FETCH_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_24120013_exu_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_REQ  = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_EXEC       = 3'd3,
    ST_WB         = 3'd4,
    ST_HALT       = 3'd5
  } state_e;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [1:0]  TRAP_NONE    = 2'b00;
  localparam logic [1:0]  TRAP_EBREAK  = 2'b01;
  localparam logic [1:0]  TRAP_ILLEGAL = 2'b10;
  localparam logic [1:0]  TRAP_FETCH   = 2'b11;
  localparam logic [7:0]  TMO_LAST     = 8'(FETCH_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           inst_q, inst_d;
  logic [1:0]            trap_q, trap_d;
  logic [7:0]            tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] cycle_q, cycle_d;
  logic [DATA_WIDTH-1:0] icnt_q, icnt_d;
  logic                  req_vld;
  logic                  rf_we;
  logic                  active;
  logic                  retire;
  logic [DATA_WIDTH-1:0] jump_pc;

  // Redirect targets are forced word-aligned.
  assign jump_pc = bus.dec_jump_target & ~DATA_WIDTH'(3);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    trap_d  = trap_q;
    tmo_d   = tmo_q;
    req_vld = 1'b0;
    rf_we   = 1'b0;
    active  = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH_REQ;
      end
      ST_FETCH_REQ: begin
        req_vld = 1'b1;
        active  = 1'b1;
        if (bus.ifu_req_ready) begin
          state_d = ST_FETCH_WAIT;
          tmo_d   = '0;
        end
      end
      ST_FETCH_WAIT: begin
        active = 1'b1;
        // A response in the final timeout cycle still wins over the timeout.
        if (bus.ifu_rsp_valid) begin
          if (bus.ifu_rsp_err) begin
            state_d = ST_HALT;
            trap_d  = TRAP_FETCH;
          end else begin
            inst_d  = bus.ifu_rsp_data;
            state_d = ST_EXEC;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_HALT;
          trap_d  = TRAP_FETCH;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_EXEC: begin
        active = 1'b1;
        if (bus.dec_illegal) begin
          state_d = ST_HALT;
          trap_d  = TRAP_ILLEGAL;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        active = 1'b1;
        retire = 1'b1;
        if (bus.dec_ebreak) begin
          state_d = ST_HALT;
          trap_d  = TRAP_EBREAK;
        end else begin
          rf_we   = bus.exu_wen && (bus.exu_waddr != '0);
          pc_d    = bus.dec_jump ? jump_pc : pc_q + DATA_WIDTH'(4);
          state_d = ST_FETCH_REQ;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cycle_d = cycle_q + DATA_WIDTH'(active);
  assign icnt_d  = icnt_q + DATA_WIDTH'(retire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      trap_q  <= TRAP_NONE;
      tmo_q   <= '0;
      cycle_q <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      trap_q  <= trap_d;
      tmo_q   <= tmo_d;
      cycle_q <= cycle_d;
      icnt_q  <= icnt_d;
    end
  end

  assign bus.ifu_req_valid = req_vld;
  assign bus.ifu_req_addr  = pc_q;
  assign bus.inst          = inst_q;
  assign bus.pc            = pc_q;
  assign bus.rf_wen        = rf_we;
  assign bus.rf_waddr      = bus.exu_waddr;
  assign bus.rf_wdata      = bus.exu_wdata;
  assign bus.halt          = (state_q == ST_HALT);
  assign bus.trap_cause    = trap_q;
  assign bus.cycle_cnt     = cycle_q;
  assign bus.inst_cnt      = icnt_q;

endmodule
